fsm_input_conditioner: RTL and testbench
========================================

FSM_INPUT_CONDITIONER -- requirements
Module: fsm_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive synchronized cycles a new level must persist before acceptance (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, debounce counter width; DEBOUNCE_CYCLES-1 SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port a_raw  input  1  asynchronous, possibly bouncing, raw input for channel a.
REQ-006 SHALL have port b_raw  input  1  asynchronous, possibly bouncing, raw input for channel b.
REQ-007 SHALL have port a  output  1  debounced, registered level of channel a, fed to the downstream FSM input a.
REQ-008 SHALL have port b  output  1  debounced, registered level of channel b, fed to the downstream FSM input b.
REQ-009 SHALL have port evt  output  1  registered one-cycle pulse, high in the cycle in which a or b (or both) has just changed.

Function
REQ-010 Each channel SHALL pass its raw input through a two-flop synchronizer (s1 <= raw, s2 <= s1); only s2 is used by later logic.
REQ-011 Each channel SHALL have an independent CNT_W-bit counter cnt and a registered output level out (a or b).
REQ-012 On each edge, if s2 == out: cnt <= 0, out unchanged.
REQ-013 On each edge, if s2 != out and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, out unchanged.
REQ-014 On each edge, if s2 != out and cnt == DEBOUNCE_CYCLES-1: out <= s2, cnt <= 0.
REQ-015 Latency: if a raw input takes a new level first sampled at edge k and holds it, out SHALL take that level at edge k+1+DEBOUNCE_CYCLES (k+5 for default), not earlier or later.
REQ-016 Any return of s2 to out before acceptance (bounce or glitch) SHALL clear cnt; counting restarts from 0 on the next mismatch.
REQ-017 Raw pulses lasting fewer than DEBOUNCE_CYCLES cycles SHALL never change out.
REQ-018 Channels SHALL be fully independent; simultaneous acceptance on both channels SHALL update a and b on the same edge.
REQ-019 evt SHALL be registered: evt <= (a changes at this edge) OR (b changes at this edge); evt is high for exactly one cycle per update edge, including when both channels update together (single pulse, not two).
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 With DEBOUNCE_CYCLES = 1, out SHALL follow s2 with one cycle delay (update at edge k+2).
REQ-022 Outputs a, b, evt SHALL be driven directly from flops (no combinational path from a_raw/b_raw).

Reset
REQ-023 While rst_n == 0 at a rising edge: s1, s2, cnt, a, b, evt of both channels SHALL all load 0.
REQ-024 Reset asserted mid-count SHALL discard the count; no pending change SHALL be accepted after release except by a fresh full sequence per REQ-015.
REQ-025 Reset values a=0, b=0 SHALL be held until acceptance, so the downstream FSM holds its state out of reset.

Verification
REQ-026 Reset: a_raw=b_raw=1 held, rst_n=0 for 3 edges -> a=b=evt=0 throughout; after release, first edge k sampling with rst_n=1 -> a=b=1 and evt=1 at edge k+5, evt=0 at k+6.
REQ-027 Clean edge: a_raw 0->1 first sampled at edge k, b_raw=0 -> a=1 at edge k+5, evt high only in cycle after k+5, b stays 0.
REQ-028 Glitch: a_raw=1 for 3 cycles then 0 (N=4) -> a stays 0, evt never asserted.
REQ-029 Bounce: a_raw 1,1,1,0,1 then held 1 (last rising sample at edge j) -> a=1 exactly at edge j+5, a single evt pulse.
REQ-030 Simultaneous: a_raw and b_raw both 0->1 sampled at same edge k -> a and b both 1 at edge k+5, evt high for exactly one cycle.
REQ-031 Reset mid-count: a_raw 0->1 at edge k, rst_n=0 at edge k+3 for 1 edge, a_raw held 1 -> a=0 at k+5; a=1 at edge (k+4)+5 = k+9.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// Input conditioner for a downstream FSM: two raw, possibly bouncing inputs are
// synchronized, debounced and presented as registered levels with a change pulse.

module fsm_input_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             out_d, out_q;

  // Synchronizer shift and debounce counter next-state; reset is synchronous.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    out_d = out_q;
    if (!rst_n) begin
      s1_d  = 1'b0;
      s2_d  = 1'b0;
      cnt_d = CNT_ZERO;
      out_d = 1'b0;
    end else if (s2_q == out_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q >= CNT_MAX) begin
      // >= rather than == so a corrupted counter still saturates instead of wrapping
      out_d = s2_q;
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    s1_q  <= s1_d;
    s2_q  <= s2_d;
    cnt_q <= cnt_d;
    out_q <= out_d;
  end

  // Change strobe only used by the parent to build the registered event.
  always_comb begin
    chg = 1'b0;
    if (out_d != out_q) begin
      chg = 1'b1;
    end else begin
      chg = 1'b0;
    end
  end

  assign level = out_q;

endmodule

module fsm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic evt
);

  logic a_chg, b_chg;
  logic evt_d, evt_q;

  fsm_input_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (a_raw),
    .level (a),
    .chg   (a_chg)
  );

  fsm_input_conditioner_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (b_raw),
    .level (b),
    .chg   (b_chg)
  );

  // One pulse per update edge, even when both channels accept together.
  always_comb begin
    evt_d = 1'b0;
    if (!rst_n) begin
      evt_d = 1'b0;
    end else begin
      evt_d = a_chg | b_chg;
    end
  end

  // Event register.
  always_ff @(posedge clk) begin
    evt_q <= evt_d;
  end

  assign evt = evt_q;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner: expectations are queued per edge
// when stimulus is driven and checked by a monitor on the falling clock edge.

module tb_fsm_input_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic a_raw, b_raw;
  logic a, b, evt;
  logic a1, b1, evt1;

  always #5 clk = ~clk;

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .evt   (evt)
  );

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) dut_n1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a1),
    .b     (b1),
    .evt   (evt1)
  );

  typedef struct {
    int    cyc;
    int    sig;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic obs_v;
  logic bseq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic observe(input int sig);
    case (sig)
      0: return a;
      1: return b;
      2: return evt;
      3: return a1;
      4: return b1;
      5: return evt1;
      default: return 1'bx;
    endcase
  endfunction

  // Scoreboard monitor: compares every expectation due at the edge just taken.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_n) begin
        obs_v = observe(sb[i].sig);
        n_vec++;
        assert (obs_v === sb[i].val) else begin
          n_miss++;
          $error("FAIL %s edge %0d sig %0d: observed %b expected %b",
                 sb[i].tag, edge_n, sb[i].sig, obs_v, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sig, input logic v, input string tag);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp3(input int c, input logic ea, input logic eb, input logic ee,
                      input string tag);
    push(c, 0, ea, tag);
    push(c, 1, eb, tag);
    push(c, 2, ee, tag);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_miss++;
      $error("FAIL drain_timeout: observed %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Drive a new raw level on both inputs and queue the full debounce timeline.
  task automatic move(input logic av, input logic bv, input logic oa, input logic ob,
                      input string tag, output int k);
    k = edge_n + 1;
    for (int c = k; c <= k + 4; c++) exp3(c, oa, ob, 1'b0, {tag, "_wait"});
    exp3(k + 5, av, bv, (av != oa) || (bv != ob), {tag, "_accept"});
    exp3(k + 6, av, bv, 1'b0, {tag, "_evt_clear"});
    a_raw = av;
    b_raw = bv;
  endtask

  initial begin
    int k;
    int j;

    // Reset held with both raw inputs high.
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int c = 1; c <= 3; c++) exp3(c, 1'b0, 1'b0, 1'b0, "reset_hold");
    repeat (3) @(negedge clk);
    k = edge_n + 1;
    for (int c = k; c <= k + 4; c++) exp3(c, 1'b0, 1'b0, 1'b0, "rst_release_wait");
    exp3(k + 5, 1'b1, 1'b1, 1'b1, "rst_release_accept");
    exp3(k + 6, 1'b1, 1'b1, 1'b0, "rst_release_evt_clear");
    rst_n = 1'b1;
    drain();

    move(1'b0, 1'b0, 1'b1, 1'b1, "both_fall", k);
    drain();

    // Clean rising edge on a, also checked on the single-cycle instance.
    move(1'b1, 1'b0, 1'b0, 1'b0, "clean_a", k);
    push(k + 1, 3, 1'b0, "n1_before");
    push(k + 2, 3, 1'b1, "n1_follow");
    push(k + 2, 4, 1'b0, "n1_b_quiet");
    push(k + 2, 5, 1'b1, "n1_evt");
    push(k + 3, 5, 1'b0, "n1_evt_clear");
    drain();

    move(1'b0, 1'b0, 1'b1, 1'b0, "a_fall", k);
    drain();

    // Three-cycle glitch must be rejected.
    k = edge_n + 1;
    for (int c = k; c <= k + 10; c++) exp3(c, 1'b0, 1'b0, 1'b0, "glitch");
    a_raw = 1'b1;
    repeat (3) @(negedge clk);
    a_raw = 1'b0;
    drain();

    // Bounce 1,1,1,0,1 then held: acceptance counted from the last rising sample.
    k = edge_n + 1;
    j = k + 4;
    for (int c = k; c <= j + 4; c++) exp3(c, 1'b0, 1'b0, 1'b0, "bounce_wait");
    exp3(j + 5, 1'b1, 1'b0, 1'b1, "bounce_accept");
    exp3(j + 6, 1'b1, 1'b0, 1'b0, "bounce_evt_clear");
    for (int i = 0; i < 5; i++) begin
      a_raw = bseq[i];
      @(negedge clk);
    end
    drain();

    move(1'b0, 1'b0, 1'b1, 1'b0, "a_fall2", k);
    drain();

    move(1'b1, 1'b1, 1'b0, 1'b0, "simul", k);
    drain();

    move(1'b0, 1'b0, 1'b1, 1'b1, "both_fall2", k);
    drain();

    // Reset pulse mid-count discards the partial count.
    k = edge_n + 1;
    for (int c = k; c <= k + 8; c++) exp3(c, 1'b0, 1'b0, 1'b0, "rst_mid_wait");
    exp3(k + 9, 1'b1, 1'b0, 1'b1, "rst_mid_accept");
    exp3(k + 10, 1'b1, 1'b0, 1'b0, "rst_mid_evt_clear");
    a_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
